// File: rtl/keypad_entry_buffer.sv
// Debounces scanner key codes into one event per press and keeps a 4-digit hex entry buffer.
// Event latency: DEBOUNCE_CYCLES edges after the first stable sample; every output is registered.
module keypad_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit ENABLE_EDIT     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        key_event,
    output logic [3:0]  event_code
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_code;
    logic [3:0]       w_code_nxt;
    logic             w_accept;
    logic [15:0]      r_digits;
    logic [15:0]      w_digits_nxt;
    logic [2:0]       r_count;
    logic [2:0]       w_count_nxt;
    logic             r_event;
    logic [3:0]       r_event_code;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_code_nxt  = key_code;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                // A drop or a different code restarts from IDLE; the new code is captured there.
                if (!key_valid || (key_code != r_code)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                    w_state_nxt = PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_valid) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (key_valid) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESSED;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_digits_nxt = r_digits;
        w_count_nxt  = r_count;
        if (w_accept) begin
            if (ENABLE_EDIT && (r_code == 4'hF)) begin
                w_digits_nxt = '0;
                w_count_nxt  = '0;
            end else if (ENABLE_EDIT && (r_code == 4'hE)) begin
                // Shifting zeros in from the left keeps an empty buffer at zero.
                w_digits_nxt = {4'h0, r_digits[15:4]};
                w_count_nxt  = (r_count == 3'd0) ? 3'd0 : r_count - 3'd1;
            end else begin
                w_digits_nxt = {r_digits[11:0], r_code};
                w_count_nxt  = (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_code       <= '0;
            r_digits     <= '0;
            r_count      <= '0;
            r_event      <= 1'b0;
            r_event_code <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_code   <= w_code_nxt;
            r_digits <= w_digits_nxt;
            r_count  <= w_count_nxt;
            r_event  <= w_accept;
            if (w_accept) begin
                r_event_code <= r_code;
            end
        end
    end

    assign digits      = r_digits;
    assign digit_count = r_count;
    assign key_event   = r_event;
    assign event_code  = r_event_code;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Randomised and directed bench for keypad_entry_buffer with edit keys on and off.
`timescale 1ns/100ps
module tb_keypad_entry_buffer;

    localparam int D = 4;

    typedef logic [3:0] nib_q_t[$];

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] digits_e, digits_n;
    logic [2:0]  count_e, count_n;
    logic        event_e, event_n;
    logic [3:0]  ecode_e, ecode_n;

    int total = 0;
    int bad   = 0;
    int ev_cnt;
    int ev_at;
    int tick_no;

    // Reference: a press is accepted once D+1 consecutive edges see the same valid code
    // while armed; re-arming needs D+1 consecutive edges with no key.
    bit         m_armed;
    int         m_run;
    int         m_rel;
    logic [3:0] m_code;
    bit         m_ev;
    logic [3:0] m_ec;
    nib_q_t     qe;
    nib_q_t     qn;

    keypad_entry_buffer #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .ENABLE_EDIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
        .digits(digits_e), .digit_count(count_e), .key_event(event_e), .event_code(ecode_e)
    );

    keypad_entry_buffer #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .ENABLE_EDIT(1'b0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
        .digits(digits_n), .digit_count(count_n), .key_event(event_n), .event_code(ecode_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input nib_q_t q);
        logic [15:0] r;
        r = '0;
        foreach (q[i]) r = {r[11:0], q[i]};
        return r;
    endfunction

    function automatic nib_q_t upd(input nib_q_t q, input bit edit, input logic [3:0] c);
        nib_q_t r;
        r = q;
        if (edit && c == 4'hF) begin
            r.delete();
        end else if (edit && c == 4'hE) begin
            if (r.size() > 0) void'(r.pop_back());
        end else begin
            r.push_back(c);
            if (r.size() > 4) void'(r.pop_front());
        end
        return r;
    endfunction

    task automatic model_reset();
        m_armed = 1'b1;
        m_run   = 0;
        m_rel   = 0;
        m_code  = '0;
        m_ev    = 1'b0;
        m_ec    = '0;
        qe.delete();
        qn.delete();
    endtask

    task automatic model_step(input logic v, input logic [3:0] c);
        m_ev = 1'b0;
        if (m_armed) begin
            if (m_run == 0) begin
                if (v) begin
                    m_run  = 1;
                    m_code = c;
                end
            end else if (v && c == m_code) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_ev    = 1'b1;
                    m_armed = 1'b0;
                    m_run   = 0;
                    m_rel   = 0;
                    m_ec    = m_code;
                    qe      = upd(qe, 1'b1, m_code);
                    qn      = upd(qn, 1'b0, m_code);
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (v) begin
                m_rel = 0;
            end else begin
                m_rel++;
                if (m_rel == D + 1) begin
                    m_armed = 1'b1;
                    m_rel   = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        chk("ev_e",  16'(event_e), 16'(m_ev));
        chk("dig_e", digits_e, pack(qe));
        chk("cnt_e", 16'(count_e), 16'(qe.size()));
        chk("ec_e",  16'(ecode_e), 16'(m_ec));
        chk("ev_n",  16'(event_n), 16'(m_ev));
        chk("dig_n", digits_n, pack(qn));
        chk("cnt_n", 16'(count_n), 16'(qn.size()));
        chk("ec_n",  16'(ecode_n), 16'(m_ec));
        if (event_e) begin
            ev_cnt++;
            ev_at = tick_no;
        end
        tick_no++;
    endtask

    task automatic hold(input logic v, input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) tick(v, c);
    endtask

    task automatic press(input logic [3:0] c);
        hold(1'b1, c, 8);
        hold(1'b0, 4'h0, 8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic start_scn();
        ev_cnt  = 0;
        ev_at   = -1;
        tick_no = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        #11;
        chk("rst_dig", digits_e, 16'h0000);
        chk("rst_cnt", 16'(count_e), 16'h0);
        chk("rst_ev",  16'(event_e), 16'h0);
        chk("rst_ec",  16'(ecode_e), 16'h0);
        #1;
        rst_n = 1'b1;

        // Clean press and latency.
        start_scn();
        hold(1'b1, 4'h5, 10);
        hold(1'b0, 4'h0, 10);
        chk("s1_evcnt", 16'(ev_cnt), 16'd1);
        chk("s1_lat",   16'(ev_at), 16'd4);
        chk("s1_dig",   digits_e, 16'h0005);
        chk("s1_ec",    16'(ecode_e), 16'h5);

        // Bounce rejection, then a mid-debounce code change.
        start_scn();
        tick(1'b1, 4'h3); tick(1'b1, 4'h3); tick(1'b0, 4'h3);
        tick(1'b1, 4'h3); tick(1'b0, 4'h3);
        hold(1'b0, 4'h0, 10);
        chk("s2_noev", 16'(ev_cnt), 16'd0);
        chk("s2_dig",  digits_e, 16'h0005);
        start_scn();
        hold(1'b1, 4'h3, 2);
        hold(1'b1, 4'h7, 10);
        hold(1'b0, 4'h0, 10);
        chk("s2_evcnt", 16'(ev_cnt), 16'd1);
        chk("s2_ec",    16'(ecode_e), 16'h7);
        chk("s2_dig2",  digits_e, 16'h0057);

        // Entry and overflow.
        do_reset();
        for (int k = 1; k <= 5; k++) press(4'(k));
        chk("s3_dig", digits_e, 16'h2345);
        chk("s3_cnt", 16'(count_e), 16'd4);

        // Edit keys.
        press(4'hF);
        press(4'hA); press(4'h1); press(4'h2);
        chk("s4_dig", digits_e, 16'h0A12);
        press(4'hE);
        chk("s4_bs",     digits_e, 16'h00A1);
        chk("s4_bs_cnt", 16'(count_e), 16'd2);
        press(4'hF);
        chk("s4_clr", digits_e, 16'h0000);
        start_scn();
        press(4'hE);
        chk("s4_bs0",     digits_e, 16'h0000);
        chk("s4_bs0_cnt", 16'(count_e), 16'd0);
        chk("s4_bs0_ev",  16'(ev_cnt), 16'd1);
        chk("s4_bs0_ec",  16'(ecode_e), 16'hE);

        // Long hold with a short release glitch.
        start_scn();
        hold(1'b1, 4'h9, 20);
        hold(1'b0, 4'h9, 2);
        hold(1'b1, 4'h9, 28);
        hold(1'b0, 4'h0, 10);
        chk("s5_evcnt", 16'(ev_cnt), 16'd1);

        // 0xF is data when edit keys are disabled.
        do_reset();
        press(4'hF);
        chk("s5_ne_dig", digits_n, 16'h000F);
        chk("s5_e_dig",  digits_e, 16'h0000);

        // Async reset in the middle of a press debounce.
        press(4'h3);
        start_scn();
        hold(1'b1, 4'h6, 2);
        #3;
        rst_n = 1'b0;
        #0.5;
        chk("s6_dig", digits_e, 16'h0000);
        chk("s6_cnt", 16'(count_e), 16'h0);
        chk("s6_ev",  16'(event_e), 16'h0);
        chk("s6_ec",  16'(ecode_e), 16'h0);
        chk("s6_ndig", digits_n, 16'h0000);
        #0.5;
        rst_n = 1'b1;
        model_reset();
        hold(1'b1, 4'h6, 8);
        hold(1'b0, 4'h0, 8);
        chk("s6_evcnt", 16'(ev_cnt), 16'd1);
        chk("s6_dig2",  digits_e, 16'h0006);

        // Random segments of held, released and bouncing keys.
        for (int s = 0; s < 300; s++) begin
            logic       v;
            logic [3:0] c;
            int         len;
            v   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            hold(v, c, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
